// File: rtl/cacheline_adapter_pkg.sv
// Shared sizing, FSM state type and beat address helper for the cache line adapter.
package cacheline_adapter_pkg;
  localparam int WORD_W    = 32;
  localparam int BEATS     = 8;
  localparam int ADDR_W    = 32;
  localparam int LINE_W    = WORD_W * BEATS;
  localparam int OFF_BITS  = $clog2(BEATS * WORD_W / 8);
  localparam int BYTE_BITS = $clog2(WORD_W / 8);
  localparam int IDX_W     = $clog2(BEATS);
  localparam int CNT_W     = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} ca_state_t;

  // tag is the line address with the in-line offset already stripped
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-OFF_BITS-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {BYTE_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cacheline_adapter_if.sv
// Word-wide main-memory beat bus; master is the adapter, slave is the memory.
interface cacheline_adapter_if;
  import cacheline_adapter_pkg::*;
  logic              mm_req;
  logic              mm_we;
  logic [ADDR_W-1:0] mm_addr;
  logic [WORD_W-1:0] mm_wdata;
  logic              mm_gnt;
  logic              mm_rvalid;
  logic [WORD_W-1:0] mm_rdata;

  modport master(output mm_req, mm_we, mm_addr, mm_wdata,
                 input  mm_gnt, mm_rvalid, mm_rdata);
  modport slave (input  mm_req, mm_we, mm_addr, mm_wdata,
                 output mm_gnt, mm_rvalid, mm_rdata);
endinterface

// File: rtl/cacheline_adapter_line_buffer.sv
// BEATS x WORD_W line register: parallel load, single-word write, word read mux.
module ca_line_buffer
  import cacheline_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [LINE_W-1:0] line_out
);
  logic [BEATS-1:0][WORD_W-1:0] words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        words <= '0;
    else if (load)  words <= load_data;
    else if (wr_en) words[wr_idx] <= wr_data;
  end

  assign rd_data  = words[rd_idx];
  assign line_out = words;
endmodule

// File: rtl/cacheline_adapter.sv
// Turns one cache line read/write-back into a BEATS-word burst on the memory bus.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [ADDR_W-1:0]    line_addr,
  input  logic [LINE_W-1:0]    line_wdata,
  output logic [LINE_W-1:0]    line_rdata,
  output logic                 ca_resp,
  output logic                 err,
  cacheline_adapter_if.master  mm
);
  ca_state_t                  state, state_nxt;
  logic [CNT_W-1:0]           iss, ret;
  logic [ADDR_W-OFF_BITS-1:0] tag_q;
  logic                       start, req, hs, ret_ok;
  logic [WORD_W-1:0]          wword, rword_unused;
  logic [LINE_W-1:0]          wline_unused;
  logic                       unused_ok;

  assign start  = (state == IDLE) && (mem_write || mem_read);
  assign req    = (state == WR_BURST) || ((state == RD_BURST) && (iss != CNT_W'(BEATS)));
  assign hs     = req && mm.mm_gnt;
  // a return is only legal while some issued beat is still unanswered
  assign ret_ok = (state == RD_BURST) && (ret != iss) && mm.mm_rvalid;
  assign err    = !rst && mm.mm_rvalid && !ret_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mem_write)     state_nxt = WR_BURST;
                else if (mem_read) state_nxt = RD_BURST;
      WR_BURST: if (hs && iss == CNT_W'(BEATS-1))     state_nxt = DONE;
      RD_BURST: if (ret_ok && ret == CNT_W'(BEATS-1)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss   <= '0;
      ret   <= '0;
      tag_q <= '0;
    end else if (start) begin
      iss   <= '0;
      ret   <= '0;
      tag_q <= line_addr[ADDR_W-1:OFF_BITS];
    end else begin
      if (hs)     iss <= iss + 1'b1;
      if (ret_ok) ret <= ret + 1'b1;
    end
  end

  ca_line_buffer u_wshadow (
    .clk, .rst,
    .load(start && mem_write), .load_data(line_wdata),
    .wr_en(1'b0), .wr_idx('0), .wr_data('0),
    .rd_idx(iss[IDX_W-1:0]), .rd_data(wword), .line_out(wline_unused)
  );

  ca_line_buffer u_rbuf (
    .clk, .rst,
    .load(1'b0), .load_data('0),
    .wr_en(ret_ok), .wr_idx(ret[IDX_W-1:0]), .wr_data(mm.mm_rdata),
    .rd_idx('0), .rd_data(rword_unused), .line_out(line_rdata)
  );

  assign mm.mm_req   = req;
  assign mm.mm_we    = (state == WR_BURST);
  assign mm.mm_addr  = req ? beat_addr(tag_q, iss[IDX_W-1:0]) : '0;
  assign mm.mm_wdata = (state == WR_BURST) ? wword : '0;
  assign ca_resp     = (state == DONE);

  assign unused_ok = &{1'b0, line_addr[OFF_BITS-1:0], wline_unused, rword_unused};
endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter against a transaction-level line/burst model.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  logic              clk, rst, mem_read, mem_write, ca_resp, err;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] line_wdata, line_rdata;

  cacheline_adapter_if mm();

  cacheline_adapter dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
    .ca_resp(ca_resp), .err(err), .mm(mm)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory behaviour knobs
  int  gnt_prob = 100, rv_prob = 100, stall_beat = -1, stall_left = 0;
  bit  rd_pat = 0, spur_en = 0, inject_rv = 0;
  logic [WORD_W-1:0] rq[$];

  // transaction model: op 0 none, 1 write burst, 2 read burst
  int  m_op = 0, m_hs = 0, m_rt = 0;
  bit  m_resp = 0;
  logic [ADDR_W-1:0] m_base = '0;
  logic [LINE_W-1:0] m_wline = '0, m_line = '0;

  int  resp_cnt = 0, err_cnt = 0, hs_total = 0;
  logic [ADDR_W-1:0] addr_log[$];
  logic [WORD_W-1:0] wd_log[$];
  bit                we_log[$];

  // memory: drives grant and returns read beats in issue order
  always @(negedge clk) begin
    if (stall_left > 0 && m_op == 1 && m_hs == stall_beat) begin
      mm.mm_gnt = 1'b0;
      stall_left--;
    end else
      mm.mm_gnt = (int'($urandom_range(99)) < gnt_prob);
    mm.mm_rvalid = 1'b0;
    mm.mm_rdata  = '0;
    if (inject_rv) begin
      mm.mm_rvalid = 1'b1; mm.mm_rdata = 32'hDEAD_BEEF; inject_rv = 0;
    end else if (rq.size() > 0 && int'($urandom_range(99)) < rv_prob) begin
      mm.mm_rvalid = 1'b1; mm.mm_rdata = rq.pop_front();
    end else if (rq.size() == 0 && spur_en && $urandom_range(99) < 5) begin
      mm.mm_rvalid = 1'b1; mm.mm_rdata = $urandom;
    end
  end

  // compare process: what the next posedge will see, then advance the model
  always @(negedge clk) begin
    bit req_e, vret;
    #2;
    if (rst) begin
      m_op = 0; m_resp = 0; m_hs = 0; m_rt = 0; m_line = '0;
    end else begin
      req_e = (m_op == 1) || (m_op == 2 && m_hs < BEATS);
      vret  = (m_op == 2) && (m_rt < m_hs);
      chk("ca_resp", ca_resp, m_resp);
      chk("mm_req", mm.mm_req, req_e);
      if (req_e) begin
        chk("mm_we", mm.mm_we, m_op == 1);
        chk("mm_addr", mm.mm_addr, m_base + m_hs * 4);
        if (m_op == 1) chk("mm_wdata", mm.mm_wdata, m_wline[m_hs*WORD_W +: WORD_W]);
      end
      chk("err", err, mm.mm_rvalid && !vret);
      chk("line_rdata", line_rdata, m_line);
      if (ca_resp) resp_cnt++;
      if (err) err_cnt++;
      if (mm.mm_req && mm.mm_gnt) begin
        hs_total++;
        addr_log.push_back(mm.mm_addr);
        wd_log.push_back(mm.mm_wdata);
        we_log.push_back(mm.mm_we);
        if (!mm.mm_we) rq.push_back(rd_pat ? 32'hA0 + WORD_W'(mm.mm_addr[4:2]) : $urandom);
      end
      if (m_resp) m_resp = 0;
      else if (m_op == 0) begin
        if (mem_write || mem_read) begin
          m_op = mem_write ? 1 : 2;
          m_base = line_addr & ~ADDR_W'(LINE_W/8 - 1);
          m_wline = line_wdata; m_hs = 0; m_rt = 0;
        end
      end else begin
        if (vret && mm.mm_rvalid) begin
          m_line[m_rt*WORD_W +: WORD_W] = mm.mm_rdata;
          m_rt++;
        end
        if (req_e && mm.mm_gnt) m_hs++;
        if ((m_op == 1 && m_hs == BEATS) || (m_op == 2 && m_rt == BEATS)) begin
          m_op = 0; m_resp = 1;
        end
      end
    end
  end

  task automatic do_op(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] wdat, input int drop_at, output int lat);
    @(negedge clk); mem_write = wr; mem_read = rd; line_addr = a; line_wdata = wdat;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == drop_at) begin mem_write = 0; mem_read = 0; end
      #1;
      if (ca_resp) begin lat = k; break; end
    end
    chk("resp_timeout", lat != 0, 1);
    @(negedge clk); mem_write = 0; mem_read = 0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk); #1;
      if (ca_resp) begin lat = k; break; end
    end
    chk("resp_timeout", lat != 0, 1);
  endtask

  initial begin
    int lat, r0, h0, e0, ok;
    bit wr, both;
    logic [LINE_W-1:0] wd;
    rst = 0; mem_read = 0; mem_write = 0; line_addr = '0; line_wdata = '0;
    #1 rst = 1;
    @(negedge clk); #1;
    chk("rst_mm_req", mm.mm_req, 0);
    chk("rst_mm_we", mm.mm_we, 0);
    chk("rst_mm_addr", mm.mm_addr, 0);
    chk("rst_mm_wdata", mm.mm_wdata, 0);
    chk("rst_ca_resp", ca_resp, 0);
    chk("rst_err", err, 0);
    chk("rst_line_rdata", line_rdata, 0);
    @(negedge clk); rst = 0;

    // 1: write, always granted
    for (int i = 0; i < BEATS; i++) wd[i*WORD_W +: WORD_W] = 32'h1111_0000 + i;
    r0 = resp_cnt; h0 = hs_total; addr_log.delete(); wd_log.delete();
    do_op(1, 0, 32'h0000_1234, wd, 0, lat);
    chk("t1_latency", lat, 9);
    repeat (2) @(negedge clk);
    chk("t1_resp_once", resp_cnt - r0, 1);
    chk("t1_beats", hs_total - h0, 8);
    chk("t1_first_addr", addr_log[0], 32'h1220);
    chk("t1_last_addr", addr_log[7], 32'h123C);
    chk("t1_last_wdata", wd_log[7], 32'h1111_0007);

    // 2: read, zero-wait memory, patterned data
    rd_pat = 1; r0 = resp_cnt;
    do_op(0, 1, 32'h40, '0, 0, lat);
    chk("t2_latency", lat, 10);
    chk("t2_line", line_rdata,
        256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
    repeat (2) @(negedge clk);
    chk("t2_resp_once", resp_cnt - r0, 1);
    rd_pat = 0;

    // 3: grant withheld three cycles on beat 2
    for (int i = 0; i < BEATS; i++) wd[i*WORD_W +: WORD_W] = $urandom;
    stall_beat = 2; stall_left = 3; h0 = hs_total; addr_log.delete();
    do_op(1, 0, 32'h0000_2000, wd, 0, lat);
    chk("t3_latency", lat, 12);
    chk("t3_beats", hs_total - h0, 8);
    chk("t3_beat2_addr", addr_log[2], 32'h2008);
    stall_beat = -1;

    // 4: both requests high -> write first, read only after DONE
    r0 = resp_cnt; we_log.delete();
    @(negedge clk); mem_write = 1; mem_read = 1; line_addr = 32'h300; line_wdata = wd;
    wait_resp(lat);
    chk("t4_wr_latency", lat, 9);
    @(negedge clk); mem_write = 0;
    wait_resp(lat);
    chk("t4_rd_latency", lat, 10);
    @(negedge clk); mem_read = 0;
    repeat (2) @(negedge clk);
    chk("t4_resp_cnt", resp_cnt - r0, 2);
    chk("t4_beats", we_log.size(), 16);
    chk("t4_first_we", we_log[0], 1);
    chk("t4_ninth_we", we_log[8], 0);

    // 6: request held through the ca_resp cycle must not restart
    h0 = hs_total; r0 = resp_cnt;
    do_op(1, 0, 32'h0000_0500, wd, 0, lat);
    #1 chk("t6_no_restart", mm.mm_req, 0);
    repeat (2) @(negedge clk);
    chk("t6_beats", hs_total - h0, 8);
    chk("t6_resp_once", resp_cnt - r0, 1);

    // 5: async reset in the middle of a read
    rv_prob = 40;
    @(negedge clk); mem_read = 1; line_addr = 32'h0000_7700;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #3;
      if (m_rt >= 4) begin ok = 1; break; end
    end
    chk("t5_reach_4_returns", ok, 1);
    @(posedge clk); #3; rst = 1; mem_read = 0;
    #1;
    chk("t5_rst_mm_req", mm.mm_req, 0);
    chk("t5_rst_mm_addr", mm.mm_addr, 0);
    chk("t5_rst_ca_resp", ca_resp, 0);
    chk("t5_rst_line", line_rdata, 0);
    @(posedge clk); #3; rst = 0;
    e0 = err_cnt; rv_prob = 100; inject_rv = 1;
    for (int k = 0; k < 50 && (rq.size() > 0 || inject_rv); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t5_late_rvalid_err", err_cnt > e0, 1);
    do_op(0, 1, 32'h0000_7700, '0, 0, lat);
    chk("t5_clean_read_latency", lat, 10);

    // randomized traffic: grant/return timing, drops, spurious returns
    spur_en = 1;
    for (int n = 0; n < 40; n++) begin
      gnt_prob = $urandom_range(100, 20);
      rv_prob  = $urandom_range(100, 20);
      for (int i = 0; i < BEATS; i++) wd[i*WORD_W +: WORD_W] = $urandom;
      wr   = 1'($urandom_range(1));
      both = ($urandom_range(7) == 0);
      do_op(wr | both, !wr | both, $urandom, wd,
            ($urandom_range(1) == 1) ? int'($urandom_range(6, 1)) : 0, lat);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    spur_en = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
